ibex_fetch_requester: RTL

// - Issues instruction-memory requests (req/gnt/rvalid) and produces the write side of the fetch FIFO
//   (valid/addr/rdata/exc push, clear). Sits between the instruction bus and the fetch FIFO in the prefetch path.
// - Tags every returned word with per-halfword exceptions: the PCC check result taken at grant, plus bus error.
// - Discards responses belonging to requests issued before a branch.

---
 rtl/ibex_fetch_requester.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/ibex_fetch_requester.sv
// ---------------------------------------------------------------------------
// ibex_fetch_requester
//
// Purpose:
//   Drives the instruction bus request channel (req/addr/gnt) and turns the
//   in-order response channel (rvalid/rdata/err) into pushes into the fetch
//   FIFO. Every granted request is remembered in a small queue together with
//   its full fetch address and the PCC check result captured at grant, so the
//   returned word can be tagged with per-halfword exceptions. Responses to
//   requests issued before a branch are dropped.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i                  fetch enable
//   branch_i/branch_addr_i redirect pulse and target (bit 1 may be set)
//   pcc_exc_i              PCC check of instr_addr_o, [0]=low, [1]=high halfword
//   instr_req_o/addr_o     bus request and word-aligned address
//   instr_gnt_i            bus grant
//   instr_rvalid_i/rdata_i/err_i  in-order bus response
//   fifo_clear_o           FIFO flush (follows branch_i)
//   fifo_valid_o/addr_o/rdata_o/exc_o  FIFO push side
//   fifo_ready_i           FIFO has room for another outstanding word
//   busy_o                 request pending or responses outstanding
// ---------------------------------------------------------------------------
`ifndef EXCEPTION_SIZE
`define EXCEPTION_SIZE 4
`endif

module ibex_fetch_requester #(
   parameter int unsigned NumOutstanding = 2,
   parameter int unsigned BusErrBit      = 0
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             req_i,
   input  logic                             branch_i,
   input  logic [31:0]                      branch_addr_i,
   input  logic [1:0][`EXCEPTION_SIZE-1:0]  pcc_exc_i,
   output logic                             instr_req_o,
   output logic [31:0]                      instr_addr_o,
   input  logic                             instr_gnt_i,
   input  logic                             instr_rvalid_i,
   input  logic [31:0]                      instr_rdata_i,
   input  logic                             instr_err_i,
   output logic                             fifo_clear_o,
   output logic                             fifo_valid_o,
   output logic [31:0]                      fifo_addr_o,
   output logic [31:0]                      fifo_rdata_o,
   output logic [1:0][`EXCEPTION_SIZE-1:0]  fifo_exc_o,
   input  logic                             fifo_ready_i,
   output logic                             busy_o
);

   localparam int unsigned ES = `EXCEPTION_SIZE;
   localparam int unsigned PW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
   localparam int unsigned CW = $clog2(NumOutstanding + 1);
   localparam logic [CW-1:0] MAX_CNT  = CW'(NumOutstanding);
   localparam logic [PW-1:0] LAST_PTR = PW'(NumOutstanding - 1);

   localparam logic [0:0] IDLE     = 1'b0;
   localparam logic [0:0] REQ_PEND = 1'b1;

   logic [0:0]          r_state;
   logic [31:0]         r_fetch_addr;
   logic                r_branch_pend;
   logic [31:0]         r_branch_tgt;

   // Outstanding-request queue, one entry per granted-but-unanswered request.
   logic [31:0]         r_q_addr [NumOutstanding];
   logic [1:0][ES-1:0]  r_q_exc  [NumOutstanding];
   logic                r_q_disc [NumOutstanding];
   logic [PW-1:0]       r_wptr;
   logic [PW-1:0]       r_rptr;
   logic [CW-1:0]       r_cnt;

   logic                w_req_idle;
   logic                w_gnt;
   logic                w_pop;
   logic                w_push_disc;
   logic [ES-1:0]       w_err_vec;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // A new request is never started in a branch cycle: the new fetch address
   // is only loaded at the end of it.
   assign w_req_idle  = req_i & ~branch_i & fifo_ready_i & (r_cnt < MAX_CNT);
   assign instr_req_o = (r_state == REQ_PEND) | w_req_idle;
   // fetch_addr only moves at grant or on a branch with no request pending,
   // so the address is stable for the whole life of a pending request.
   assign instr_addr_o = {r_fetch_addr[31:2], 2'b00};
   assign w_gnt        = instr_req_o & instr_gnt_i;
   assign w_pop        = instr_rvalid_i & (r_cnt != '0);
   // A request granted after (or in the same cycle as) a branch belongs to
   // the old stream.
   assign w_push_disc  = r_branch_pend | branch_i;

   always_comb begin
      w_err_vec            = '0;
      w_err_vec[BusErrBit] = instr_err_i;
   end

   assign fifo_clear_o    = branch_i;
   assign fifo_valid_o    = w_pop & ~r_q_disc[r_rptr] & ~branch_i;
   assign fifo_addr_o     = r_q_addr[r_rptr];
   assign fifo_rdata_o    = instr_rdata_i;
   assign fifo_exc_o[0]   = r_q_exc[r_rptr][0] | w_err_vec;
   assign fifo_exc_o[1]   = r_q_exc[r_rptr][1] | w_err_vec;
   assign busy_o          = (r_state == REQ_PEND) | (r_cnt != '0);

   // Request state, fetch address and pending branch target
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state       <= IDLE;
         r_fetch_addr  <= '0;
         r_branch_pend <= 1'b0;
         r_branch_tgt  <= '0;
      end else begin
         case (r_state)
            IDLE:     if (instr_req_o && !instr_gnt_i) r_state <= REQ_PEND;
            REQ_PEND: if (instr_gnt_i) r_state <= IDLE;
            default:  r_state <= IDLE;
         endcase

         if (w_gnt) begin
            if (branch_i) begin
               r_fetch_addr <= branch_addr_i;
            end else if (r_branch_pend) begin
               r_fetch_addr <= r_branch_tgt;
            end else begin
               r_fetch_addr <= r_fetch_addr + 32'd4;
            end
            r_branch_pend <= 1'b0;
         end else if (branch_i) begin
            if (r_state == REQ_PEND) begin
               // The address on the bus must not move; park the target.
               r_branch_pend <= 1'b1;
               r_branch_tgt  <= branch_addr_i;
            end else begin
               r_fetch_addr  <= branch_addr_i;
            end
         end
      end
   end

   // Outstanding queue: push at grant, pop at response
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
         for (int i = 0; i < int'(NumOutstanding); i++) begin
            r_q_addr[i] <= '0;
            r_q_exc[i]  <= '0;
            r_q_disc[i] <= 1'b0;
         end
      end else begin
         if (branch_i) begin
            for (int i = 0; i < int'(NumOutstanding); i++) begin
               r_q_disc[i] <= 1'b1;
            end
         end
         if (w_gnt) begin
            r_q_addr[r_wptr] <= r_fetch_addr;
            r_q_exc[r_wptr]  <= pcc_exc_i;
            r_q_disc[r_wptr] <= w_push_disc;
            r_wptr           <= ptr_inc(r_wptr);
         end
         if (w_pop) begin
            r_rptr <= ptr_inc(r_rptr);
         end
         case ({w_gnt, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

`ifndef SYNTHESIS
   a_no_spurious_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(instr_rvalid_i && (r_cnt == '0)));
   a_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (instr_req_o && !instr_gnt_i) |=> $stable(instr_addr_o));
   a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
      r_cnt <= MAX_CNT);
`endif

endmodule
